// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrowing store path: size codes, FSM states
// and the alignment rule used at request accept.
package store_narrow_rmw_pkg;

    localparam int DATA_W = 32;

    // Store size as encoded on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Store sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_ERR   = 2'b11
    } state_e;

    // True when a request of this size cannot be issued at this byte offset.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrow_rmw_lane_merge.sv
// Combinational lane merge: overlays the low byte/half/word of the store data
// onto an existing memory word at the given little-endian byte offset.
module store_narrow_rmw_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] data,
    input  size_e             size,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] new_word
);

    // Replace only the lanes covered by the store; other lanes keep old_word.
    always_comb begin
        // NOTE: assign the default before the case so every path drives new_word and no latch is inferred.
        new_word = old_word;
        case (size)
            SZ_BYTE: new_word[{offset, 3'b000} +: 8]     = data[7:0];
            SZ_HALF: new_word[{offset[1], 4'b0000} +: 16] = data[15:0];
            SZ_WORD: new_word = data;
            default: new_word = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit for a word-wide RAM without byte enables.
// Word stores write directly; byte/half stores read the word, merge, write back.
// Misaligned or illegal requests are rejected with a one-cycle misalign pulse.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              misalign
);

    state_e              state_q, state_d;
    logic [MEM_AW-1:0]   addr_q;
    logic [1:0]          off_q;
    logic [DATA_W-1:0]   data_q;
    size_e               size_q;
    logic [DATA_W-1:0]   merged;
    logic                accept;
    size_e               req_size_e;

    // Address bits above the RAM window wrap around and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    assign req_size_e = size_e'(req_size);
    assign accept     = req_valid && (state_q == ST_IDLE);

    // Next-state logic of the store sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_misaligned(req_size_e, req_addr[1:0])) state_d = ST_ERR;
                    else if (req_size_e == SZ_WORD)             state_d = ST_WRITE;
                    else                                        state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Request capture; held until the next accept so mem_addr stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            off_q  <= '0;
            data_q <= '0;
            size_q <= SZ_BYTE;
        end else if (accept) begin
            addr_q <= req_addr[MEM_AW+1:2];
            off_q  <= req_addr[1:0];
            data_q <= req_data;
            size_q <= req_size_e;
        end
    end

    store_narrow_rmw_lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .size     (size_q),
        .offset   (off_q),
        .new_word (merged)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign mem_rd    = (state_q == ST_READ);
    assign mem_wr    = (state_q == ST_WRITE);
    assign done      = (state_q == ST_WRITE);
    assign misalign  = (state_q == ST_ERR);
    assign mem_addr  = addr_q;
    // RAM read data arrives in the WRITE cycle, one cycle after mem_rd.
    assign mem_wdata = (state_q == ST_WRITE) ? merged : '0;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: directed vector table, reset abort, back-to-back
// requests and randomized stores checked against a word-array memory model.
module tb_store_narrow_rmw;

    localparam int MEM_AW = 10;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              misalign;

    logic [31:0]       ram     [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic              poke_en;
    logic [MEM_AW-1:0] poke_idx;
    logic [31:0]       poke_val;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_count = 0;
    int accept_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] ram_word;
        logic [31:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    store_narrow_rmw #(.MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with a bench-side preload port.
    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        else begin
            if (mem_rd) mem_rdata <= ram[mem_addr];
            if (mem_wr) ram[mem_addr] <= mem_wdata;
        end
    end

    // Cycle counter, accept log and write-pulse counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready && rst_n) accept_q.push_back(cyc);
        if (mem_wr) wr_count <= wr_count + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t: bound expired", name, $time);
    endtask

    // Reference: a store overwrites the bytes it covers, computed with masks.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] size, input logic [31:0] addr);
        int unsigned sh;
        logic [31:0] mask;
        sh = 8 * int'(addr[1:0]);
        case (size)
            2'd0:    mask = 32'h0000_00FF << sh;
            2'd1:    mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_idx = MEM_AW'(idx);
        poke_val = val;
        poke_en  = 1'b1;
        @(negedge clk);
        poke_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("wait_ready");
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                             input logic exp_err, input logic [31:0] exp_wdata);
        int idx;
        idx = int'(addr[MEM_AW+1:2]);
        @(negedge clk);
        wait_ready();
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("ready_busy", 32'(req_ready), 32'd0);
        if (exp_err) begin
            check("err_misalign", 32'(misalign), 32'd1);
            check("err_no_rd", 32'(mem_rd), 32'd0);
            check("err_no_wr", 32'(mem_wr), 32'd0);
            @(negedge clk);
            check("err_ready_back", 32'(req_ready), 32'd1);
            check("err_pulse_end", 32'(misalign), 32'd0);
            check("err_no_wr2", 32'(mem_wr), 32'd0);
        end else if (size == 2'd2) begin
            check("sw_wr", 32'(mem_wr), 32'd1);
            check("sw_done", 32'(done), 32'd1);
            check("sw_no_rd", 32'(mem_rd), 32'd0);
            check("sw_addr", 32'(mem_addr), 32'(idx));
            check("sw_wdata", mem_wdata, exp_wdata);
            @(negedge clk);
            check("sw_idle", 32'(req_ready), 32'd1);
            check("sw_wr_end", 32'(mem_wr), 32'd0);
        end else begin
            check("sub_rd", 32'(mem_rd), 32'd1);
            check("sub_no_wr", 32'(mem_wr), 32'd0);
            check("sub_addr", 32'(mem_addr), 32'(idx));
            @(negedge clk);
            check("sub_wr", 32'(mem_wr), 32'd1);
            check("sub_done", 32'(done), 32'd1);
            check("sub_wdata", mem_wdata, exp_wdata);
            @(negedge clk);
            check("sub_idle", 32'(req_ready), 32'd1);
            check("sub_wr_end", 32'(mem_wr), 32'd0);
        end
        if (!exp_err) ref_mem[idx] = exp_wdata;
        check("ram_word", ram[idx], ref_mem[idx]);
    endtask

    initial begin
        int base, wr_before, n;
        logic [31:0] a, d;
        logic [1:0]  s;
        logic        e;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        poke_en   = 1'b0;
        poke_idx  = '0;
        poke_val  = '0;

        vecs[0] = '{32'h10, 32'hDEADBEEF, 2'd2, 32'h11223344, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{32'h13, 32'h123456AB, 2'd0, 32'h11223344, 32'hAB223344, 1'b0};
        vecs[2] = '{32'h12, 32'hFFFF5566, 2'd1, 32'h11223344, 32'h55663344, 1'b0};
        vecs[3] = '{32'h10, 32'hFFFF5566, 2'd1, 32'h11223344, 32'h11225566, 1'b0};
        vecs[4] = '{32'h11, 32'hAAAA7777, 2'd1, 32'h11223344, 32'h0,        1'b1};
        vecs[5] = '{32'h12, 32'hBBBB8888, 2'd2, 32'h11223344, 32'h0,        1'b1};
        vecs[6] = '{32'h10, 32'hCCCC9999, 2'd3, 32'h11223344, 32'h0,        1'b1};

        // Preload the RAM while the DUT is held in reset.
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);

        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_wr", 32'(mem_wr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            poke(int'(vecs[i].addr[MEM_AW+1:2]), vecs[i].ram_word);
            run_store(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].exp_err, vecs[i].exp_wdata);
        end

        // Reset during READ aborts the byte store with no write.
        poke(8, 32'h11223344);
        @(negedge clk);
        wait_ready();
        req_addr  = 32'h21;
        req_data  = 32'h0000_0099;
        req_size  = 2'd0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_read", 32'(mem_rd), 32'd1);
        wr_before = wr_count;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rd", 32'(mem_rd), 32'd0);
        check("abort_wr", 32'(mem_wr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_misalign", 32'(misalign), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_write", 32'(wr_count), 32'(wr_before));
        check("abort_ram", ram[8], 32'h11223344);
        run_store(32'h20, 32'hCAFEF00D, 2'd2, 1'b0, 32'hCAFEF00D);

        // Back-to-back SB, SH, SW with req_valid held high.
        poke(16'h40, 32'h01020304);
        poke(16'h41, 32'h05060708);
        poke(16'h42, 32'h090A0B0C);
        base      = accept_q.size();
        wr_before = wr_count;
        @(negedge clk);
        req_addr  = 32'h101;
        req_data  = 32'hFFFF_FFEE;
        req_size  = 2'd0;
        req_valid = 1'b1;
        n = 0;
        while (accept_q.size() < base + 1 && n < 10) begin @(negedge clk); n++; end
        req_addr = 32'h106;
        req_data = 32'h1234_ABCD;
        req_size = 2'd1;
        n = 0;
        while (accept_q.size() < base + 2 && n < 10) begin @(negedge clk); n++; end
        req_addr = 32'h108;
        req_data = 32'h7654_3210;
        req_size = 2'd2;
        n = 0;
        while (accept_q.size() < base + 3 && n < 10) begin @(negedge clk); n++; end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        ref_mem[16'h40] = ref_merge(ref_mem[16'h40], 32'hFFFF_FFEE, 2'd0, 32'h101);
        ref_mem[16'h41] = ref_merge(ref_mem[16'h41], 32'h1234_ABCD, 2'd1, 32'h106);
        ref_mem[16'h42] = ref_merge(ref_mem[16'h42], 32'h7654_3210, 2'd2, 32'h108);
        if (accept_q.size() != base + 3) begin
            fail_now("b2b_accepts");
        end else begin
            check("b2b_gap1", 32'(accept_q[base+1] - accept_q[base]), 32'd3);
            check("b2b_gap2", 32'(accept_q[base+2] - accept_q[base+1]), 32'd3);
        end
        check("b2b_writes", 32'(wr_count - wr_before), 32'd3);
        check("b2b_ram0", ram[16'h40], ref_mem[16'h40]);
        check("b2b_ram1", ram[16'h41], ref_mem[16'h41]);
        check("b2b_ram2", ram[16'h42], ref_mem[16'h42]);

        // Randomized stores, including address bits above the RAM window.
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            d = $urandom;
            s = 2'($urandom_range(0, 3));
            e = ref_err(a, s);
            run_store(a, d, s, e, e ? 32'h0 : ref_merge(ref_mem[int'(a[MEM_AW+1:2])], d, s, a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
